// File: rtl/serial_fas.sv
// serial_fas: bit-serial N-bit adder/subtractor built around one full adder/subtractor cell.
// Operands are shifted out LSB first, one bit per clock, with carry/borrow held in a flop.
module serial_fas #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         a_ns,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_sh_q, a_sh_d;
    logic [N-1:0]    b_sh_q, b_sh_d;
    logic [N-1:0]    sum_sh_q, sum_sh_d;
    logic            c_q, c_d;
    logic            mode_q, mode_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N-1:0]    s_q, s_d;
    logic            cout_q, cout_d;

    logic            ai, bi, bit_s, c_nxt;
    logic [N-1:0]    sum_nxt;

    // Single-bit cell: sum bit plus carry (add) or borrow (subtract).
    always_comb begin
        ai      = a_sh_q[0];
        bi      = b_sh_q[0];
        bit_s   = ai ^ bi ^ c_q;
        c_nxt   = mode_q ? ((ai & bi) | (ai & c_q) | (bi & c_q))
                         : ((~ai & bi) | (~ai & c_q) | (bi & c_q));
        sum_nxt = {bit_s, sum_sh_q[N-1:1]};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        c_d      = c_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        s_d      = s_q;
        cout_d   = cout_q;

        unique case (state_q)
            IDLE, DONE: begin
                // DONE always leaves; a start seen on that leaving edge is taken
                // directly so held-start operation repeats every N+1 clocks.
                state_d = IDLE;
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    mode_d   = a_ns;
                    sum_sh_d = '0;
                    c_d      = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_nxt;
                c_d      = c_nxt;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Last bit: publish the result as DONE is entered.
                    s_d     = sum_nxt;
                    cout_d  = c_nxt;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            c_q      <= 1'b0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            s_q      <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            c_q      <= c_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_fas.sv
// tb_serial_fas: self-checking bench for serial_fas (N=8).
module tb_serial_fas;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         a_ns;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         cout;

    int errors = 0;
    int checks = 0;

    serial_fas #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_ns  (a_ns),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] va;
        logic [N-1:0] vb;
        logic         vm;
        logic [N-1:0] exp_s;
        logic         exp_c;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain N+1 bit arithmetic; the top bit is carry (add) or borrow (sub).
    function automatic logic [N:0] ref_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic m);
        logic [N:0] ex, ey;
        ex = {1'b0, x};
        ey = {1'b0, y};
        return m ? (ex + ey) : (ex - ey);
    endfunction

    // One start-pulsed operation with cycle-by-cycle handshake checks.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tm, input bit inject);
        logic [N-1:0] prev_s;
        logic         prev_c;
        logic [N:0]   r;
        r = ref_op(ta, tb_, tm);
        @(negedge clk);
        prev_s = s;
        prev_c = cout;
        a = ta; b = tb_; a_ns = tm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("s_hold", 32'(s), 32'(prev_s));
            chk("cout_hold", 32'(cout), 32'(prev_c));
            if (inject && k == 3) begin
                a = ~ta; b = 8'h77; a_ns = ~tm; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_done", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        chk("s_result", 32'(s), 32'(r[N-1:0]));
        chk("cout_result", 32'(cout), 32'(r[N]));
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("s_after", 32'(s), 32'(r[N-1:0]));
    endtask

    initial begin
        logic [N:0] r;
        logic [N-1:0] ra, rb;
        logic rm;

        vecs[0] = '{8'h5A, 8'h33, 1'b1, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
        vecs[3] = '{8'h01, 8'h02, 1'b0, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        rst_n = 1'b0; start = 1'b0; a_ns = 1'b0; a = '0; b = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors: sanity-check each table entry against the model, then the DUT.
        for (int i = 0; i < 6; i++) begin
            r = ref_op(vecs[i].va, vecs[i].vb, vecs[i].vm);
            chk("table_model", 32'(r), 32'({vecs[i].exp_c, vecs[i].exp_s}));
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vm, 1'b0);
            chk("table_s", 32'(s), 32'(vecs[i].exp_s));
            chk("table_cout", 32'(cout), 32'(vecs[i].exp_c));
        end

        // Inputs changed and start pulsed mid-RUN must be ignored.
        run_op(8'h5A, 8'h33, 1'b1, 1'b1);
        chk("protect_s", 32'(s), 32'h8D);
        chk("protect_cout", 32'(cout), 32'd0);

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset during RUN bit 4.
        @(negedge clk);
        a = 8'hC3; b = 8'h5C; a_ns = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_s", 32'(s), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("arst_no_done", 32'(done), 32'd0);
            chk("arst_no_busy", 32'(busy), 32'd0);
        end

        // Start held high: a new operation every N+1 clocks.
        for (int j = 0; j < 5; j++) begin
            ra = N'($urandom); rb = N'($urandom); rm = 1'($urandom);
            a = ra; b = rb; a_ns = rm; start = 1'b1;
            r = ref_op(ra, rb, rm);
            for (int k = 0; k < int'(N); k++) begin
                @(negedge clk);
                chk("b2b_busy", 32'(busy), 32'd1);
                chk("b2b_done_run", 32'(done), 32'd0);
                a = ~ra; b = ~rb; a_ns = ~rm;
            end
            @(negedge clk);
            chk("b2b_done", 32'(done), 32'd1);
            chk("b2b_busy_off", 32'(busy), 32'd0);
            chk("b2b_s", 32'(s), 32'(r[N-1:0]));
            chk("b2b_cout", 32'(cout), 32'(r[N]));
        end
        start = 1'b0;
        @(negedge clk);
        chk("b2b_tail_done", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
